// File: rtl/tl_a_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tl_a_arbiter2: two-master TL-UL A/D arbiter. The A channel is shared       |
// | round-robin per burst. D responses are routed back by the source tag.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tl_a_arbiter2 #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [3:0]  m0_a_size,
  input  logic [5:0]  m0_a_source,
  input  logic [29:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [3:0]  m1_a_size,
  input  logic [5:0]  m1_a_source,
  input  logic [29:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [2:0]  out_a_param,
  output logic [3:0]  out_a_size,
  output logic [6:0]  out_a_source,
  output logic [29:0] out_a_address,
  output logic [3:0]  out_a_mask,
  output logic [31:0] out_a_data,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [1:0]  out_d_param,
  input  logic [3:0]  out_d_size,
  input  logic [6:0]  out_d_source,
  input  logic        out_d_denied,
  input  logic        out_d_corrupt,
  input  logic [31:0] out_d_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [3:0]  m0_d_size,
  output logic [5:0]  m0_d_source,
  output logic        m0_d_denied,
  output logic        m0_d_corrupt,
  output logic [31:0] m0_d_data,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [3:0]  m1_d_size,
  output logic [5:0]  m1_d_source,
  output logic        m1_d_denied,
  output logic        m1_d_corrupt,
  output logic [31:0] m1_d_data,
  output logic        idle
);

  localparam logic [3:0] c_max = 4'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t     r_state;
  logic       r_grant;
  logic       r_rr_ptr;
  logic [3:0] r_beat_left;
  logic [3:0] r_d_beat;
  logic [3:0] r_cnt0;
  logic [3:0] r_cnt1;

  logic       w_elig0, w_elig1, w_act, w_gnt;
  logic       w_a_fire, w_first_fire;
  logic [3:0] w_a_extra, w_d_extra;
  logic       w_dest, w_d_fire, w_d_last;

  // Beats beyond the first for a multi-beat message (size <= 6).
  function automatic logic [3:0] burst_extra(input logic data_op, input logic [3:0] size);
    logic [3:0] r;
    r = 4'd0;
    if (data_op) begin
      case (size)
        4'd3:    r = 4'd1;
        4'd4:    r = 4'd3;
        4'd5:    r = 4'd7;
        4'd6:    r = 4'd15;
        default: r = 4'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc, input logic dec);
    logic dec_eff;
    dec_eff = dec && (c != 4'd0);
    if (inc && !dec_eff) return c + 4'd1;
    if (dec_eff && !inc) return c - 4'd1;
    return c;
  endfunction

  always_comb begin
    w_elig0 = m0_a_valid && (r_cnt0 < c_max);
    w_elig1 = m1_a_valid && (r_cnt1 < c_max);
    if (r_state == ST_BURST) begin
      w_act = 1'b1;
      w_gnt = r_grant;
    end else begin
      w_act = w_elig0 || w_elig1;
      w_gnt = (w_elig0 && w_elig1) ? r_rr_ptr : w_elig1;
    end
  end

  assign out_a_valid   = w_act && (w_gnt ? m1_a_valid : m0_a_valid);
  assign out_a_opcode  = w_gnt ? m1_a_opcode  : m0_a_opcode;
  assign out_a_param   = w_gnt ? m1_a_param   : m0_a_param;
  assign out_a_size    = w_gnt ? m1_a_size    : m0_a_size;
  assign out_a_source  = {w_gnt, (w_gnt ? m1_a_source : m0_a_source)};
  assign out_a_address = w_gnt ? m1_a_address : m0_a_address;
  assign out_a_mask    = w_gnt ? m1_a_mask    : m0_a_mask;
  assign out_a_data    = w_gnt ? m1_a_data    : m0_a_data;
  assign m0_a_ready    = w_act && !w_gnt && out_a_ready;
  assign m1_a_ready    = w_act &&  w_gnt && out_a_ready;

  assign w_a_fire     = out_a_valid && out_a_ready;
  assign w_first_fire = w_a_fire && (r_state == ST_IDLE);
  assign w_a_extra    = burst_extra(out_a_opcode <= 3'd1, out_a_size);

  assign w_dest      = out_d_source[6];
  assign m0_d_valid  = out_d_valid && !w_dest;
  assign m1_d_valid  = out_d_valid &&  w_dest;
  assign out_d_ready = w_dest ? m1_d_ready : m0_d_ready;
  assign w_d_fire    = out_d_valid && out_d_ready;
  assign w_d_extra   = burst_extra(out_d_opcode == 3'd1, out_d_size);
  assign w_d_last    = w_d_fire && ((r_d_beat == 4'd0) ? (w_d_extra == 4'd0) : (r_d_beat == 4'd1));

  assign m0_d_opcode  = out_d_opcode;
  assign m0_d_param   = out_d_param;
  assign m0_d_size    = out_d_size;
  assign m0_d_source  = out_d_source[5:0];
  assign m0_d_denied  = out_d_denied;
  assign m0_d_corrupt = out_d_corrupt;
  assign m0_d_data    = out_d_data;
  assign m1_d_opcode  = out_d_opcode;
  assign m1_d_param   = out_d_param;
  assign m1_d_size    = out_d_size;
  assign m1_d_source  = out_d_source[5:0];
  assign m1_d_denied  = out_d_denied;
  assign m1_d_corrupt = out_d_corrupt;
  assign m1_d_data    = out_d_data;

  assign idle = (r_state == ST_IDLE) && (r_cnt0 == 4'd0) && (r_cnt1 == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_beat_left <= 4'd0;
      r_d_beat    <= 4'd0;
      r_cnt0      <= 4'd0;
      r_cnt1      <= 4'd0;
    end else begin
      r_cnt0 <= cnt_next(r_cnt0, w_first_fire && !w_gnt, w_d_last && !w_dest);
      r_cnt1 <= cnt_next(r_cnt1, w_first_fire &&  w_gnt, w_d_last &&  w_dest);
      case (r_state)
        ST_IDLE: begin
          if (w_first_fire) begin
            if (w_a_extra != 4'd0) begin
              r_state     <= ST_BURST;
              r_beat_left <= w_a_extra;
              r_grant     <= w_gnt;
            end else begin
              r_rr_ptr <= ~w_gnt;
            end
          end
        end
        ST_BURST: begin
          if (w_a_fire) begin
            r_beat_left <= r_beat_left - 4'd1;
            if (r_beat_left == 4'd1) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= ~r_grant;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // D beat counter holds remaining beats of the response in progress.
      if (w_d_fire)
        r_d_beat <= (r_d_beat == 4'd0) ? w_d_extra : r_d_beat - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/tl_a_arbiter2.md
# tl_a_arbiter2

Two-master TileLink-UL arbiter that shares a single A channel (request) and a single D channel (response) of the downstream TL queue/monitor path between two requesters. It round-robins the A channel at burst granularity and tags each request source with the master index. It routes D responses back by that tag and tracks outstanding transactions per master so it can throttle and report idle. It sits directly upstream of the A/D queue pair that feeds the TL monitor.

## Interface
- MAX_OUTSTANDING, 8: maximum in-flight transactions per master (1..15); counters are 4 bits.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mN_a_valid / mN_a_ready  input / output  1 / 1  per-master A handshake, N = 0, 1.
- mN_a_opcode, mN_a_param, mN_a_size  input  3, 3, 4  per-master A fields.
- mN_a_source  input  6  per-master source ID.
- mN_a_address, mN_a_mask, mN_a_data  input  30, 4, 32  per-master A payload.
- out_a_valid / out_a_ready  output / input  1 / 1  downstream A handshake.
- out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data  output  3, 3, 4, 30, 4, 32  selected master's fields, passed through unchanged.
- out_a_source  output  7  {grant index, mN_a_source}.
- out_d_valid / out_d_ready  input / output  1 / 1  downstream D handshake.
- out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_denied, out_d_corrupt, out_d_data  input  3, 2, 4, 7, 1, 1, 32  D fields.
- mN_d_valid / mN_d_ready  output / input  1 / 1  per-master D handshake.
- mN_d_opcode, mN_d_param, mN_d_size, mN_d_denied, mN_d_corrupt, mN_d_data  output  3, 2, 4, 1, 1, 32  D fields broadcast to both masters.
- mN_d_source  output  6  out_d_source[5:0].
- idle  output  1  both outstanding counters are zero and no A burst is locked.

## Operation
- Beat count: A beats = 1 << (size-2) when opcode is PutFullData (0) or PutPartialData (1) and size > 2, else 1. D beats = 1 << (size-2) when opcode is AccessAckData (1) and size > 2, else 1. Size is limited to ≤ 6 (16 beats); larger sizes are illegal and behaviour is unspecified.
- A state machine:
  - IDLE: the eligible set is masters with a_valid=1 and cnt < MAX_OUTSTANDING. With one eligible master, grant it. With both eligible, grant the master selected by rr_ptr.
  - First-beat fire (out_a_valid & out_a_ready): if beats > 1, go to BURST with beat_left = beats-1 and the grant held.
  - BURST: the grant is fixed and the other master sees a_ready=0. The locked master is not throttled by its counter. Decrement beat_left on each fire; return to IDLE when the last beat fires.
  - rr_ptr becomes the non-granted master's index when a burst's last beat (or a single beat) fires.
- Datapath: A is purely combinational, with zero added latency. out_a_valid = granted mN_a_valid. The granted mN_a_ready = out_a_ready; the non-granted master sees a_ready=0.
- D routing: the destination is m{out_d_source[6]}. Only that master sees d_valid=out_d_valid, and out_d_ready = its d_ready. The D field outputs are driven to both masters regardless of destination.
- D beat tracking: a separate D beat counter identifies the last beat of each D response.
- Outstanding counters:
  - cntN increments on the first-beat fire of an A message from master N.
  - cntN decrements on the last-beat fire of a D response to master N.
  - Increment and decrement in the same cycle leave cntN unchanged.
  - D with cntN == 0 is a protocol error; the counter saturates at 0 and does not wrap.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, beat_left=0, D beat counter=0, cnt0=cnt1=0.
  - idle=1.
  - All ready/valid outputs follow their combinational inputs. With no valid inputs, every valid output is 0.
- Grant is recomputed every cycle in IDLE. A master that drops valid before a fire loses the grant with no penalty.
- The lock takes effect on the cycle after the first-beat fire. Beats of one burst are never interleaved with the other master's beats.
- Reset asserted mid-burst or mid-D-response clears all state immediately. No partial beats are replayed.

## Test plan
- Both masters issue a 4-byte Get (size=2) continuously with out_a_ready=1 -> grants alternate m0, m1, m0, ... starting with m0; out_a_source[6] toggles every cycle.
- m0 issues PutFull with size=4 (4 beats) while m1 is valid throughout -> the 4 m0 beats are contiguous, then m1 is granted; m1_a_ready=0 for those 4 cycles.
- out_d_source=7'h45, opcode AccessAckData, size=3 -> 2 beats are delivered to m1 only with m1_d_source=6'h05; m0_d_valid stays 0; cnt1 decrements once, on the second beat.
- m0 issues 8 Gets with no D returns (MAX_OUTSTANDING=8) -> m0_a_ready=0 and m1 keeps being granted. One D response to m0 restores m0's eligibility on the next cycle.
- A fire and D last-beat fire for m1 in the same cycle -> cnt1 is unchanged. After all responses return, idle=1.
- Reset pulse in the middle of a 16-beat Put (size=6) -> the grant drops and idle=1. The next request is arbitrated fresh with m0 priority.
